// File: rtl/bp_stream_io_responder.sv
// bp_stream_io_responder
//
// Host-side endpoint for processor-initiated uncached IO traffic. Each
// accepted uc_wr / uc_rd command is serialized as an NBF packet
// {opcode, addr, data} onto the outgoing stream, LSB flit first. Read data
// comes back on the incoming stream. One response per command is returned on
// io_resp. Only one transaction is in flight at a time.
//
// Ports
//   clk_i, reset_i                      clock, synchronous active-high reset
//   io_cmd_i / _v_i / _ready_o          command message in (valid-then-ready)
//   io_resp_o / _v_o / _yumi_i          response message out
//   stream_v_o / stream_data_o / stream_yumi_i   outgoing NBF flits
//   stream_v_i / stream_data_i / stream_ready_o  incoming read-data flits
//
// Message layout, LSB first:
//   msg_type[3:0], addr[paddr-1:0], size[2:0], payload, then data[cce_block].
//   payload = {lce_id, way_id, coherence state(3), prefetch(1)}.
module bp_stream_io_responder #(
    parameter int paddr_width_p       = 40,
    parameter int dword_width_p       = 64,
    parameter int cce_block_width_p   = 512,
    parameter int lce_id_width_p      = 1,
    parameter int lce_assoc_p         = 8,
    parameter int stream_data_width_p = 32,
    parameter int nbf_opcode_width_p  = 8,
    parameter int nbf_addr_width_p    = paddr_width_p,
    parameter int nbf_data_width_p    = dword_width_p,

    localparam int payload_width_lp     = lce_id_width_p + $clog2(lce_assoc_p) + 4,
    localparam int header_width_lp      = 4 + paddr_width_p + 3 + payload_width_lp,
    localparam int cce_mem_msg_width_lp = header_width_lp + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
    input  logic                            io_cmd_v_i,
    output logic                            io_cmd_ready_o,

    output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
    output logic                            io_resp_v_o,
    input  logic                            io_resp_yumi_i,

    output logic                            stream_v_o,
    output logic [stream_data_width_p-1:0]  stream_data_o,
    input  logic                            stream_yumi_i,

    input  logic                            stream_v_i,
    input  logic [stream_data_width_p-1:0]  stream_data_i,
    output logic                            stream_ready_o
);

    localparam int nbf_width_lp      = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
    localparam int nbf_num_flits_lp  = (nbf_width_lp + stream_data_width_p - 1) / stream_data_width_p;
    localparam int data_num_flits_lp = (nbf_data_width_p + stream_data_width_p - 1) / stream_data_width_p;
    localparam int pkt_width_lp      = nbf_num_flits_lp * stream_data_width_p;
    localparam int rdata_width_lp    = data_num_flits_lp * stream_data_width_p;
    localparam int max_flits_lp      = (nbf_num_flits_lp > data_num_flits_lp)
                                       ? nbf_num_flits_lp : data_num_flits_lp;
    localparam int cnt_width_lp      = $clog2(max_flits_lp) + 1;

    localparam logic [3:0] MSG_UC_RD = 4'd2;
    localparam logic [3:0] MSG_UC_WR = 4'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Sizes above 8 bytes are clamped to the 8-byte opcode; the NBF data
    // field only carries one dword.
    function automatic logic [7:0] nbf_opcode(input logic is_rd, input logic [2:0] size);
        logic [1:0] sz;
        sz = (size > 3'd3) ? 2'd3 : size[1:0];
        return {3'b000, is_rd, 2'b00, sz};
    endfunction

    // Keep the low 2^size bytes of the collected read data.
    function automatic logic [rdata_width_lp-1:0] size_mask(input logic [2:0] size);
        logic [rdata_width_lp-1:0] m;
        int nbytes;
        nbytes = 1 << size;
        m = '0;
        for (int i = 0; i < rdata_width_lp / 8; i++) begin
            if (i < nbytes) m[i*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    logic [1:0]                    state_r;
    logic [cnt_width_lp-1:0]       cnt_r;
    logic [header_width_lp-1:0]    hdr_r;
    logic [nbf_data_width_p-1:0]   wdata_r;
    logic [rdata_width_lp-1:0]     rdata_r;

    logic [3:0]                    cmd_type;
    logic                          cmd_is_uc;
    logic [3:0]                    hdr_type;
    logic [paddr_width_p-1:0]      hdr_addr;
    logic [2:0]                    hdr_size;
    logic                          hdr_is_rd;
    logic [pkt_width_lp-1:0]       pkt;
    logic [cce_block_width_p-1:0]  resp_data;
    logic                          unused_cmd_data;

    assign cmd_type  = io_cmd_i[3:0];
    assign cmd_is_uc = (cmd_type == MSG_UC_RD) || (cmd_type == MSG_UC_WR);

    assign hdr_type  = hdr_r[3:0];
    assign hdr_addr  = hdr_r[4 +: paddr_width_p];
    assign hdr_size  = hdr_r[4 + paddr_width_p +: 3];
    assign hdr_is_rd = (hdr_type == MSG_UC_RD);

    // Only the low dword of the command data travels in the packet.
    assign unused_cmd_data = ^io_cmd_i[cce_mem_msg_width_lp-1:header_width_lp+nbf_data_width_p];

    // wdata_r is already zero for reads, so the packet needs no type check.
    assign pkt = pkt_width_lp'({nbf_opcode_width_p'(nbf_opcode(hdr_is_rd, hdr_size)),
                                hdr_addr[nbf_addr_width_p-1:0],
                                wdata_r});

    // rdata_r is cleared on accept, so writes and unsupported types return 0.
    assign resp_data = cce_block_width_p'(rdata_r & size_mask(hdr_size));

    assign io_cmd_ready_o = (state_r == ST_IDLE);
    assign stream_v_o     = (state_r == ST_SEND);
    assign stream_ready_o = (state_r == ST_RDATA);
    assign io_resp_v_o    = (state_r == ST_RESP);
    assign io_resp_o      = {resp_data, hdr_r};
    assign stream_data_o  = (state_r == ST_SEND)
                            ? pkt[cnt_r*stream_data_width_p +: stream_data_width_p]
                            : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            hdr_r   <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (io_cmd_v_i) begin
                        hdr_r   <= io_cmd_i[header_width_lp-1:0];
                        wdata_r <= (cmd_type == MSG_UC_WR)
                                   ? io_cmd_i[header_width_lp +: nbf_data_width_p] : '0;
                        rdata_r <= '0;
                        cnt_r   <= '0;
                        state_r <= cmd_is_uc ? ST_SEND : ST_RESP;
                    end
                end
                ST_SEND: begin
                    if (stream_yumi_i) begin
                        if (cnt_r == cnt_width_lp'(nbf_num_flits_lp - 1)) begin
                            cnt_r   <= '0;
                            state_r <= hdr_is_rd ? ST_RDATA : ST_RESP;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (stream_v_i) begin
                        rdata_r[cnt_r*stream_data_width_p +: stream_data_width_p] <= stream_data_i;
                        if (cnt_r == cnt_width_lp'(data_num_flits_lp - 1)) begin
                            cnt_r   <= '0;
                            state_r <= ST_RESP;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    if (io_resp_yumi_i) state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_stream_io_responder.sv
module tb_bp_stream_io_responder;

    localparam int PADDR = 40;
    localparam int HDR_W = 4 + PADDR + 3 + 8;
    localparam int MSG_W = HDR_W + 512;
    localparam int NF    = 4;
    localparam int DF    = 2;

    typedef logic [MSG_W-1:0] w_t;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic [MSG_W-1:0] io_cmd_i = '0;
    logic             io_cmd_v_i = 1'b0;
    logic             io_cmd_ready_o;
    logic [MSG_W-1:0] io_resp_o;
    logic             io_resp_v_o;
    logic             io_resp_yumi_i = 1'b0;
    logic             stream_v_o;
    logic [31:0]      stream_data_o;
    logic             stream_yumi_i = 1'b0;
    logic             stream_v_i = 1'b0;
    logic [31:0]      stream_data_i = '0;
    logic             stream_ready_o;

    int total = 0;
    int bad   = 0;

    bp_stream_io_responder dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .io_cmd_i       (io_cmd_i),
        .io_cmd_v_i     (io_cmd_v_i),
        .io_cmd_ready_o (io_cmd_ready_o),
        .io_resp_o      (io_resp_o),
        .io_resp_v_o    (io_resp_v_o),
        .io_resp_yumi_i (io_resp_yumi_i),
        .stream_v_o     (stream_v_o),
        .stream_data_o  (stream_data_o),
        .stream_yumi_i  (stream_yumi_i),
        .stream_v_i     (stream_v_i),
        .stream_data_i  (stream_data_i),
        .stream_ready_o (stream_ready_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input w_t act, input w_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event occurred, required none", nm);
    endtask

    function automatic w_t mk_cmd(input logic [3:0] mt, input logic [2:0] sz,
                                  input logic [39:0] addr, input logic [63:0] data);
        w_t m;
        m = '0;
        m[3:0]            = mt;
        m[43:4]           = addr;
        m[46:44]          = sz;
        m[54:47]          = 8'h5A;
        m[HDR_W +: 64]    = data;
        m[HDR_W+64 +: 64] = ~data;
        return m;
    endfunction

    // One full transaction. Must be entered at a negedge with the DUT idle.
    task automatic run_txn(input w_t cmd, input logic [31:0] rf0, input logic [31:0] rf1,
                           input int stall, input bit chk_lat,
                           output logic [31:0] f3, output logic [63:0] rdat);
        logic [3:0]   mt;
        logic [2:0]   sz;
        logic [39:0]  addr;
        logic [63:0]  wd;
        logic [127:0] pkt;
        logic [63:0]  rd;
        logic [7:0]   op;
        w_t           exp_resp;
        bit           is_rd, is_uc, done, seen;
        int           nf_exp, df_exp, k, j, cyc, nbytes;

        mt     = cmd[3:0];
        addr   = cmd[43:4];
        sz     = cmd[46:44];
        wd     = cmd[HDR_W +: 64];
        is_rd  = (mt == 4'd2);
        is_uc  = is_rd || (mt == 4'd3);
        nf_exp = is_uc ? NF : 0;
        df_exp = is_rd ? DF : 0;
        op     = (is_rd ? 8'h10 : 8'h00) + ((sz > 3'd3) ? 8'd3 : 8'(sz));
        pkt    = (128'(op) << 104) + (128'(addr) << 64) + (is_rd ? 128'd0 : 128'(wd));
        rd     = '0;
        if (is_rd) begin
            rd     = {rf1, rf0};
            nbytes = 1 << sz;
            if (nbytes < 8) rd = rd % (64'd1 << (8 * nbytes));
        end
        exp_resp = '0;
        exp_resp[HDR_W-1:0]   = cmd[HDR_W-1:0];
        exp_resp[HDR_W +: 64] = rd;
        f3   = '0;
        rdat = '0;

        chk("cmd_ready_idle", w_t'(io_cmd_ready_o), w_t'(1'b1));
        io_cmd_i   = cmd;
        io_cmd_v_i = 1'b1;
        @(negedge clk);
        io_cmd_v_i = 1'b0;
        io_cmd_i   = ~cmd;

        k = 0; j = 0; cyc = 1; done = 0; seen = 0;
        while (!done && cyc < 1000) begin
            stream_yumi_i  = 1'b0;
            stream_v_i     = 1'b0;
            stream_data_i  = $urandom;
            io_resp_yumi_i = 1'b0;
            if (stream_v_o) begin
                if (k >= nf_exp) fail_evt("extra_flit");
                else begin
                    chk($sformatf("flit%0d", k), w_t'(stream_data_o), w_t'(pkt[k*32 +: 32]));
                    if (stall == 0 || $urandom_range(99) >= stall) begin
                        stream_yumi_i = 1'b1;
                        if (k == 3) f3 = stream_data_o;
                        k++;
                    end
                end
            end
            if (stream_ready_o) begin
                if (k < nf_exp || j >= df_exp) fail_evt("unexpected_rdata_ready");
                else if (stall == 0 || $urandom_range(99) >= stall) begin
                    stream_v_i    = 1'b1;
                    stream_data_i = (j == 0) ? rf0 : rf1;
                    j++;
                end
            end
            if (io_resp_v_o) begin
                if (!seen) begin
                    seen = 1;
                    chk("flits_before_resp", w_t'(k), w_t'(nf_exp));
                    chk("rflits_before_resp", w_t'(j), w_t'(df_exp));
                    if (chk_lat) chk("resp_latency", w_t'(cyc), w_t'(1 + nf_exp + df_exp));
                end
                chk("resp_msg", io_resp_o, exp_resp);
                if (stall == 0 || $urandom_range(99) >= stall) begin
                    io_resp_yumi_i = 1'b1;
                    rdat = io_resp_o[HDR_W +: 64];
                    done = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        stream_yumi_i  = 1'b0;
        stream_v_i     = 1'b0;
        io_resp_yumi_i = 1'b0;
        if (!done) fail_evt("txn_timeout");
    endtask

    typedef struct {
        logic [3:0]  mt;
        logic [2:0]  sz;
        logic [39:0] addr;
        logic [63:0] data;
        logic [31:0] rf0;
        logic [31:0] rf1;
        logic [31:0] exp_f3;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] f3;
        logic [63:0] rdat;
        w_t          cmd;
        int          r;

        vecs[0] = '{4'd3, 3'd3, 40'h00_8000_1000, 64'h1122334455667788, 32'h0, 32'h0,
                    32'h0000_0300, 64'h0};
        vecs[1] = '{4'd2, 3'd2, 40'h00_0030_0000, 64'h0, 32'hDEADBEEF, 32'hCAFEF00D,
                    32'h0000_1200, 64'h00000000DEADBEEF};
        vecs[2] = '{4'd2, 3'd0, 40'h12_3456_789A, 64'h0, 32'h11223344, 32'h55667788,
                    32'h0000_1012, 64'h44};
        vecs[3] = '{4'd2, 3'd1, 40'hFF_0000_0004, 64'h0, 32'hA5A5BEEF, 32'h12345678,
                    32'h0000_11FF, 64'hBEEF};
        vecs[4] = '{4'd2, 3'd3, 40'h00_0000_0000, 64'h0, 32'h89ABCDEF, 32'h01234567,
                    32'h0000_1300, 64'h0123456789ABCDEF};
        vecs[5] = '{4'd3, 3'd0, 40'h01_0000_0000, 64'h00000000000000FF, 32'h0, 32'h0,
                    32'h0000_0001, 64'h0};
        vecs[6] = '{4'd1, 3'd3, 40'h00_0000_1000, 64'hFFFF0000FFFF0000, 32'h0, 32'h0,
                    32'h0, 64'h0};

        // reset, then idle
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_cmd_ready", w_t'(io_cmd_ready_o), w_t'(1'b1));
        chk("idle_stream_v", w_t'(stream_v_o), w_t'(1'b0));
        chk("idle_resp_v", w_t'(io_resp_v_o), w_t'(1'b0));
        chk("idle_stream_ready", w_t'(stream_ready_o), w_t'(1'b0));

        // directed vectors, no backpressure
        for (int i = 0; i < 7; i++) begin
            cmd = mk_cmd(vecs[i].mt, vecs[i].sz, vecs[i].addr, vecs[i].data);
            run_txn(cmd, vecs[i].rf0, vecs[i].rf1, 0, 1'b1, f3, rdat);
            chk($sformatf("vec%0d_flit3", i), w_t'(f3), w_t'(vecs[i].exp_f3));
            chk($sformatf("vec%0d_rdata", i), w_t'(rdat), w_t'(vecs[i].exp_rdata));
        end

        // reset in the middle of a uc_rd after two flits
        cmd = mk_cmd(4'd2, 3'd3, 40'h00_4000_0008, 64'h0);
        io_cmd_i   = cmd;
        io_cmd_v_i = 1'b1;
        @(negedge clk);
        io_cmd_v_i    = 1'b0;
        stream_yumi_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_stream_v", w_t'(stream_v_o), w_t'(1'b1));
        stream_yumi_i = 1'b0;
        reset_i       = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk("post_reset_stream_v", w_t'(stream_v_o), w_t'(1'b0));
        chk("post_reset_resp_v", w_t'(io_resp_v_o), w_t'(1'b0));
        chk("post_reset_stream_ready", w_t'(stream_ready_o), w_t'(1'b0));
        chk("post_reset_cmd_ready", w_t'(io_cmd_ready_o), w_t'(1'b1));
        cmd = mk_cmd(4'd3, 3'd3, 40'h00_8000_2000, 64'h0102030405060708);
        run_txn(cmd, 32'h0, 32'h0, 0, 1'b1, f3, rdat);
        chk("post_reset_wr_rdata", w_t'(rdat), w_t'(64'h0));

        // randomized mixed commands with 50% stalls
        for (int n = 0; n < 100; n++) begin
            r = $urandom_range(9);
            cmd = mk_cmd((r < 4) ? 4'd3 : (r < 8) ? 4'd2 : (r == 8) ? 4'd1 : 4'd0,
                         3'($urandom_range(3)),
                         40'({$urandom, $urandom}),
                         {$urandom, $urandom});
            run_txn(cmd, $urandom, $urandom, 50, 1'b0, f3, rdat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
